// File: rtl/ddfs_env_adsr.sv
// ADSR envelope sequencer feeding the DDFS amplitude-modulation input.
// A 32-bit accumulator (0x8000_0000 = 1.0) is stepped on prescaled ticks; env is its Q2.14 view.
module ddfs_env_adsr #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_on,
    input  logic        note_off,
    input  logic [31:0] attack_step,
    input  logic [31:0] decay_step,
    input  logic [31:0] sustain_level,
    input  logic [31:0] release_step,
    output logic [15:0] env,
    output logic [2:0]  state_o,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] DECAY   = 3'd2;
    localparam logic [2:0] SUSTAIN = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic [31:0] ACC_MAX = 32'h8000_0000;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic [31:0]   acc_reg;
    logic [31:0]   acc_next;
    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [2:0]    tick_state;
    logic          busy_reg;
    logic          done_reg;
    logic          done_next;
    logic          tick;

    logic [31:0]   sustain_clamped;
    logic [32:0]   attack_sum;
    logic [32:0]   decay_diff;
    logic          attack_hit;
    logic          decay_hit;
    logic          release_hit;

    // Free-running time base, deliberately untouched by note events
    assign tick = (presc_reg == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign sustain_clamped = (sustain_level > ACC_MAX) ? ACC_MAX : sustain_level;
    assign attack_sum      = {1'b0, acc_reg} + {1'b0, attack_step};
    assign decay_diff      = {1'b0, acc_reg} - {1'b0, decay_step};

    assign attack_hit  = (attack_step == 32'd0) || (attack_sum >= {1'b0, ACC_MAX});
    // A borrow out of the subtraction means the decay overshot below zero, hence below SL
    assign decay_hit   = (decay_step == 32'd0) || decay_diff[32] ||
                         (decay_diff[31:0] <= sustain_clamped);
    assign release_hit = (release_step == 32'd0) || (acc_reg <= release_step);

    // Tick actions: the accumulator always follows the state held before the edge
    always_comb begin
        acc_next   = acc_reg;
        tick_state = state_reg;
        if (tick) begin
            case (state_reg)
                ATTACK: begin
                    if (attack_hit) begin
                        acc_next   = ACC_MAX;
                        tick_state = DECAY;
                    end else begin
                        acc_next = attack_sum[31:0];
                    end
                end
                DECAY: begin
                    if (decay_hit) begin
                        acc_next   = sustain_clamped;
                        tick_state = SUSTAIN;
                    end else begin
                        acc_next = decay_diff[31:0];
                    end
                end
                SUSTAIN: begin
                    acc_next = sustain_clamped;
                end
                RELEASE: begin
                    if (release_hit) begin
                        acc_next   = 32'd0;
                        tick_state = IDLE;
                    end else begin
                        acc_next = acc_reg - release_step;
                    end
                end
                default: begin
                    acc_next = 32'd0;
                end
            endcase
        end
    end

    // Note events override whatever the tick would have done to the state
    always_comb begin
        state_next = tick_state;
        if (note_on) begin
            state_next = ATTACK;
        end else if (note_off && (state_reg == ATTACK || state_reg == DECAY ||
                                  state_reg == SUSTAIN)) begin
            state_next = RELEASE;
        end
    end

    assign done_next = (state_reg == RELEASE) && (state_next == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg   <= 32'd0;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= done_next;
        end
    end

    assign env     = {1'b0, acc_reg[31:17]};
    assign state_o = state_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
